// File: rtl/rotation_cmd_parser.sv
// Rotation command parser.
// Takes ASCII lines of the form "L<digits>" or "R<digits>" ending in LF and
// turns each well-formed line into one {direction, distance} command.
// Malformed lines are counted, raise a sticky error flag, and produce no command.
module rotation_cmd_parser #(
    parameter int DIST_WIDTH    = 32,
    parameter int ERR_CNT_WIDTH = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     byte_valid_i,
    input  logic [7:0]               byte_data_i,
    output logic                     byte_ready_o,
    output logic                     cmd_valid_o,
    input  logic                     cmd_ready_i,
    output logic                     cmd_direction_o,
    output logic [DIST_WIDTH-1:0]    cmd_distance_o,
    output logic [31:0]              cmd_count_o,
    output logic                     err_o,
    output logic [ERR_CNT_WIDTH-1:0] err_count_o
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] DIGITS = 2'd1;
    localparam logic [1:0] EMIT   = 2'd2;
    localparam logic [1:0] SKIP   = 2'd3;

    localparam logic [7:0] CH_L     = 8'h4C;
    localparam logic [7:0] CH_R     = 8'h52;
    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_LF    = 8'h0A;
    localparam logic [7:0] CH_SPACE = 8'h20;
    localparam logic [7:0] CH_ZERO  = 8'h30;
    localparam logic [7:0] CH_NINE  = 8'h39;

    logic [1:0]               state_q, state_d;
    logic                     dir_q, dir_d;
    logic [DIST_WIDTH-1:0]    acc_q, acc_d;
    logic                     digit_seen_q, digit_seen_d;
    logic                     cmd_dir_q, cmd_dir_d;
    logic [DIST_WIDTH-1:0]    cmd_dist_q, cmd_dist_d;
    logic [31:0]              cmd_count_q, cmd_count_d;
    logic                     err_q, err_d;
    logic [ERR_CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;

    logic                     byte_fire;
    logic                     err_event;
    logic                     is_digit;
    logic [DIST_WIDTH+3:0]    acc_wide;
    logic [DIST_WIDTH+3:0]    acc_next_wide;
    logic                     acc_overflow;

    assign byte_ready_o    = (state_q != EMIT);
    assign cmd_valid_o     = (state_q == EMIT);
    assign cmd_direction_o = cmd_dir_q;
    assign cmd_distance_o  = cmd_dist_q;
    assign cmd_count_o     = cmd_count_q;
    assign err_o           = err_q;
    assign err_count_o     = err_cnt_q;

    assign byte_fire = byte_valid_i & byte_ready_o;
    assign is_digit  = (byte_data_i >= CH_ZERO) && (byte_data_i <= CH_NINE);

    // Four spare bits make acc*10+digit exact, so any set top bit means overflow.
    assign acc_wide      = {4'b0000, acc_q};
    assign acc_next_wide = (acc_wide << 3) + (acc_wide << 1)
                         + (DIST_WIDTH+4)'(byte_data_i[3:0]);
    assign acc_overflow  = |acc_next_wide[DIST_WIDTH+3:DIST_WIDTH];

    // Line parsing FSM plus command/error bookkeeping.
    always_comb begin
        state_d      = state_q;
        dir_d        = dir_q;
        acc_d        = acc_q;
        digit_seen_d = digit_seen_q;
        cmd_dir_d    = cmd_dir_q;
        cmd_dist_d   = cmd_dist_q;
        cmd_count_d  = cmd_count_q;
        err_event    = 1'b0;

        case (state_q)
            IDLE: begin
                if (byte_fire) begin
                    if (byte_data_i == CH_L || byte_data_i == CH_R) begin
                        dir_d        = (byte_data_i == CH_R);
                        acc_d        = '0;
                        digit_seen_d = 1'b0;
                        state_d      = DIGITS;
                    end else if (byte_data_i == CH_CR || byte_data_i == CH_LF ||
                                 byte_data_i == CH_SPACE) begin
                        state_d = IDLE;
                    end else begin
                        err_event = 1'b1;
                        state_d   = SKIP;
                    end
                end
            end
            DIGITS: begin
                if (byte_fire) begin
                    if (is_digit) begin
                        if (acc_overflow) begin
                            err_event = 1'b1;
                            state_d   = SKIP;
                        end else begin
                            acc_d        = acc_next_wide[DIST_WIDTH-1:0];
                            digit_seen_d = 1'b1;
                        end
                    end else if (byte_data_i == CH_CR) begin
                        state_d = DIGITS;
                    end else if (byte_data_i == CH_LF) begin
                        if (digit_seen_q) begin
                            cmd_dir_d  = dir_q;
                            cmd_dist_d = acc_q;
                            state_d    = EMIT;
                        end else begin
                            err_event = 1'b1;
                            state_d   = IDLE;
                        end
                    end else begin
                        err_event = 1'b1;
                        state_d   = SKIP;
                    end
                end
            end
            EMIT: begin
                if (cmd_ready_i) begin
                    cmd_count_d = cmd_count_q + 32'd1;
                    state_d     = IDLE;
                end
            end
            SKIP: begin
                if (byte_fire && byte_data_i == CH_LF) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        err_d     = err_q | err_event;
        err_cnt_d = err_cnt_q;
        if (err_event && (err_cnt_q != {ERR_CNT_WIDTH{1'b1}})) begin
            err_cnt_d = err_cnt_q + ERR_CNT_WIDTH'(1);
        end
    end

    // State registers with synchronous active-low reset taking priority.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            dir_q        <= 1'b0;
            acc_q        <= '0;
            digit_seen_q <= 1'b0;
            cmd_dir_q    <= 1'b0;
            cmd_dist_q   <= '0;
            cmd_count_q  <= '0;
            err_q        <= 1'b0;
            err_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            dir_q        <= dir_d;
            acc_q        <= acc_d;
            digit_seen_q <= digit_seen_d;
            cmd_dir_q    <= cmd_dir_d;
            cmd_dist_q   <= cmd_dist_d;
            cmd_count_q  <= cmd_count_d;
            err_q        <= err_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

endmodule
